motor_cmd_sequencer: RTL and testbench

MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

---
 rtl/motor_pkg.sv | 18 +
 rtl/cmd_fifo.sv | 39 +++
 rtl/motor_cmd_sequencer.sv | 96 +++++++++
 tb/tb_motor_cmd_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared widths, opcodes, FSM states and command layout for the motor sequencer
package motor_pkg;
  localparam int PWR_W = 7;
  localparam int DUR_W = 8;
  typedef enum logic [7:0] {
    OP_STOP   = 8'h00,
    OP_FWD    = 8'h01,
    OP_REV    = 8'h02,
    OP_SPIN_L = 8'h03,
    OP_SPIN_R = 8'h04
  } op_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  typedef struct packed {
    logic [7:0]       op;
    logic [7:0]       pwr;
    logic [DUR_W-1:0] dur;
  } cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous command queue with flush, full/empty flags and occupancy count
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/motor_cmd_sequencer.sv
// motor_cmd_sequencer: queued timed drive-command executor; define MOTOR_RAMP_EN for a 1-per-tick power ramp
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd1,
  input  logic [7:0]       cmd2,
  input  logic [7:0]       cmd3,
  input  logic             abort,
  output logic [PWR_W-1:0] pwr_left,
  output logic [PWR_W-1:0] pwr_right,
  output logic             dir_left,
  output logic             dir_right,
  output logic             busy,
  output logic             cmd_done,
  output logic             bad_op
);
  localparam int PW = $clog2(PRESCALE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, nxt;
  cmd_t head;
  logic full, empty;
  logic [CW-1:0] count;
  logic [7:0] op;
  logic [PWR_W-1:0] pwr, lvl;
  logic [DUR_W-1:0] rem;
  logic [PW-1:0] pre;
  logic run, mov, wrap, unused_ok;
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (cmd_valid && !abort),
    .pop   (state == S_LOAD),
    .din   ({cmd1, cmd2, cmd3}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign unused_ok = ^{head.pwr[7], count};
  assign wrap = pre == PW'(PRESCALE - 1);
  assign run = state == S_RUN;
  assign mov = op inside {OP_FWD, OP_REV, OP_SPIN_L, OP_SPIN_R};
  always_comb begin
    nxt = abort ? S_IDLE
        : state == S_LOAD ? (head.dur == '0 ? S_DONE : S_RUN)
        : state == S_RUN ? ((wrap && rem == DUR_W'(1)) ? S_DONE : S_RUN)
        : empty ? S_IDLE : S_LOAD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op <= '0;
      pwr <= '0;
      rem <= '0;
      pre <= '0;
      bad_op <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_LOAD && !abort) begin
        op <= head.op;
        pwr <= head.pwr[PWR_W-1:0];
        rem <= head.dur;
        pre <= '0;
        bad_op <= bad_op || (head.op > OP_SPIN_R);
      end else if (run) begin
        pre <= wrap ? '0 : pre + 1'b1;
        rem <= wrap ? rem - 1'b1 : rem;
      end
    end
  end
`ifdef MOTOR_RAMP_EN
  logic [PWR_W-1:0] ramp;
  always_ff @(posedge clk) begin
    if (reset || state == S_LOAD) ramp <= '0;
    else if (run && wrap && ramp < pwr) ramp <= ramp + 1'b1;
  end
  assign lvl = ramp;
`else
  assign lvl = pwr;
`endif
  assign pwr_left = (run && mov) ? lvl : '0;
  assign pwr_right = (run && mov) ? lvl : '0;
  assign dir_left = !(run && (op == OP_REV || op == OP_SPIN_L));
  assign dir_right = !(run && (op == OP_REV || op == OP_SPIN_R));
  assign busy = state != S_IDLE;
  assign cmd_done = state == S_DONE;
  assign cmd_ready = !full;
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb_motor_cmd_sequencer: directed and random checks against a command-schedule reference model
module tb_motor_cmd_sequencer;
  localparam int P = 4;
  localparam int D = 4;
  typedef struct packed {
    bit       load;
    bit       busy;
    bit       done;
    bit       bad;
    bit [6:0] pl;
    bit [6:0] pr;
    bit       dl;
    bit       dr;
  } rec_t;
  localparam rec_t IDLE = '{load: 1'b0, busy: 1'b0, done: 1'b0, bad: 1'b0, pl: 7'd0, pr: 7'd0, dl: 1'b1, dr: 1'b1};
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic abort = 1'b0;
  logic [7:0] cmd1 = '0, cmd2 = '0, cmd3 = '0;
  logic cmd_ready, dir_left, dir_right, busy, cmd_done, bad_op;
  logic [6:0] pwr_left, pwr_right;
  rec_t sched[$];
  bit [23:0] q[$];
  bit bad_m;
  bit acc;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  motor_cmd_sequencer #(.PRESCALE(P), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd1      (cmd1),
    .cmd2      (cmd2),
    .cmd3      (cmd3),
    .abort     (abort),
    .pwr_left  (pwr_left),
    .pwr_right (pwr_right),
    .dir_left  (dir_left),
    .dir_right (dir_right),
    .busy      (busy),
    .cmd_done  (cmd_done),
    .bad_op    (bad_op)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic void expand(bit [23:0] c);
    bit [7:0] op = c[23:16];
    bit [6:0] p = c[14:8];
    int d = int'(c[7:0]);
    rec_t r;
    r = '{load: 1'b1, busy: 1'b1, done: 1'b0, bad: (op > 8'd4), pl: 7'd0, pr: 7'd0, dl: 1'b1, dr: 1'b1};
    sched.push_back(r);
    for (int t = 0; t < d * P; t++) begin
      int lv = int'(p);
`ifdef MOTOR_RAMP_EN
      lv = (t / P < int'(p)) ? t / P : int'(p);
`endif
      r = '{load: 1'b0, busy: 1'b1, done: 1'b0, bad: 1'b0, pl: 7'd0, pr: 7'd0, dl: 1'b1, dr: 1'b1};
      if (op >= 8'd1 && op <= 8'd4) begin
        r.pl = 7'(lv);
        r.pr = 7'(lv);
        r.dl = (op == 8'd1 || op == 8'd4);
        r.dr = (op == 8'd1 || op == 8'd3);
      end
      sched.push_back(r);
    end
    r = '{load: 1'b0, busy: 1'b1, done: 1'b1, bad: 1'b0, pl: 7'd0, pr: 7'd0, dl: 1'b1, dr: 1'b1};
    sched.push_back(r);
  endfunction
  task automatic cyc(input bit v, input bit [7:0] a, input bit [7:0] b, input bit [7:0] c, input bit ab, output bit ok);
    rec_t r;
    bit nx;
    @(negedge clk);
    r = sched.size() > 0 ? sched[0] : IDLE;
    chk("pwr_left", int'(pwr_left), int'(r.pl));
    chk("pwr_right", int'(pwr_right), int'(r.pr));
    chk("dir_left", int'(dir_left), int'(r.dl));
    chk("dir_right", int'(dir_right), int'(r.dr));
    chk("busy", int'(busy), int'(r.busy));
    chk("cmd_done", int'(cmd_done), int'(r.done));
    chk("cmd_ready", int'(cmd_ready), int'(q.size() < D));
    chk("bad_op", int'(bad_op), int'(bad_m));
    cmd_valid = v;
    cmd1 = a;
    cmd2 = b;
    cmd3 = c;
    abort = ab;
    ok = v && !ab && q.size() < D;
    if (ab) begin
      q.delete();
      sched.delete();
    end else begin
      nx = sched.size() <= 1 && !r.load && q.size() > 0;
      if (r.load) begin
        bad_m |= r.bad;
        void'(q.pop_front());
      end
      if (sched.size() > 0) void'(sched.pop_front());
      if (nx) expand(q[0]);
      if (ok) q.push_back({a, b, c});
    end
  endtask
  task automatic idle(input int n);
    bit ok;
    repeat (n) cyc(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, ok);
  endtask
  task automatic send(input bit [7:0] a, input bit [7:0] b, input bit [7:0] c);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) cyc(1'b1, a, b, c, 1'b0, ok);
    chk("send_accepted", int'(ok), 1);
  endtask
  task automatic drain();
    int k = 0;
    while ((sched.size() > 0 || q.size() > 0) && k < 500) begin
      idle(1);
      k++;
    end
    chk("drain_in_bound", int'(k < 500), 1);
    idle(2);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    sched.delete();
    bad_m = 1'b0;
  endtask
  initial begin
    do_reset();
    idle(2);
    send(8'h01, 8'h40, 8'd3);
    drain();
    send(8'h01, 8'h11, 8'd1);
    send(8'h02, 8'h22, 8'd2);
    send(8'h03, 8'h33, 8'd1);
    send(8'h04, 8'h44, 8'd1);
    send(8'h01, 8'h55, 8'd1);
    drain();
    send(8'h07, 8'h20, 8'd2);
    drain();
    idle(5);
    do_reset();
    idle(2);
    send(8'h03, 8'h30, 8'd10);
    send(8'h01, 8'h10, 8'd1);
    send(8'h02, 8'h10, 8'd1);
    idle(12);
    cyc(1'b1, 8'h01, 8'h12, 8'd1, 1'b1, acc);
    idle(4);
    send(8'h02, 8'h10, 8'd0);
    drain();
    send(8'h01, 8'h50, 8'd5);
    idle(8);
    do_reset();
    idle(3);
    send(8'h01, 8'h03, 8'd6);
    drain();
    send(8'h01, 8'h7f, 8'd1);
    send(8'h02, 8'h00, 8'd1);
    drain();
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 6)), 8'($urandom), 8'($urandom_range(0, 3)),
          $urandom_range(0, 39) == 0, acc);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
